uart_bus_responder: RTL and testbench

- Bus slave responder for the UART window (address prefix 8'h03, 1 address bit: data and status), and the serial master driving txd and sampling rxd.
- Accepts CPU byte writes into a TX FIFO that is serialised 8N1 on txd.
- Deserialises rxd into an RX FIFO that the CPU pops by reading the data address.
- Sits between the bus decoder and the board UART pins.

---
 rtl/uart_bus_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
// UART bus responder: CPU-facing DATA/STATUS window backed by TX/RX FIFOs,
// with an 8N1 serialiser on txd and a synchronised deserialiser on rxd.

module uart_bus_responder_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

module uart_bus_responder #(
  parameter int CLKS_PER_BIT = 96,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] data_wr,
  input  logic [3:0]  mask,
  output logic [31:0] data_rd,
  output logic [31:0] data_rd_2,
  output logic        stall,
  output logic        txd,
  input  logic        rxd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic       w_wr_data, w_rd_data, w_rd_stat;
  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_bit_done;
  logic [7:0] w_tx_head;
  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_bit_done;
  logic       w_rx_stop_sample, w_ovf_set, w_ferr_set;
  logic [7:0] w_rx_head;
  logic       w_unused_bits;

  tx_state_t  r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_shift;
  logic       r_txd;

  rx_state_t  r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic       r_rx_meta, r_rx_sync, r_rx_wait_high;
  logic       r_ferr, r_ovf;

  assign w_unused_bits = ^{address[31:3], address[1:0], data_wr[31:8], mask[3:1]};

  // Write wins over a simultaneous read; such a read has no side effects.
  assign w_wr_data = write && !address[2] && mask[0];
  assign w_rd_data = read && !write && !address[2];
  assign w_rd_stat = read && !write && address[2];

  assign stall     = w_wr_data && w_tx_full;
  assign w_tx_push = w_wr_data && !w_tx_full;
  assign w_rx_pop  = w_rd_data && !w_rx_empty;
  assign data_rd_2 = 32'h0;

  always_comb begin
    data_rd = 32'h0;
    if (read) begin
      if (address[2])
        data_rd = {28'h0, r_ovf, r_ferr, !w_rx_empty, !w_tx_full};
      else if (!w_rx_empty)
        data_rd = {24'h0, w_rx_head};
    end
  end

  uart_bus_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_data(data_wr[7:0]),
    .i_pop(w_tx_pop), .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  uart_bus_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .i_push(w_rx_push), .i_data(r_rx_shift),
    .i_pop(w_rx_pop), .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // ---------------- transmitter ----------------
  assign w_tx_bit_done = (r_tx_cnt == BIT_LAST);
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_bit_done));
  assign txd = r_txd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_cnt   <= '0;
            r_txd      <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_done) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_done) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_done) begin
            r_tx_cnt <= '0;
            // Chain straight into the next start bit when more bytes wait.
            if (w_tx_pop) begin
              r_tx_shift <= w_tx_head;
              r_txd      <= 1'b0;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx_bit_done    = (r_rx_cnt == BIT_LAST);
  assign w_rx_stop_sample = (r_rx_state == RX_STOP) && !r_rx_wait_high && w_rx_bit_done;
  assign w_rx_push        = w_rx_stop_sample && r_rx_sync;
  assign w_ferr_set       = w_rx_stop_sample && !r_rx_sync;
  assign w_ovf_set        = w_rx_push && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ferr <= w_ferr_set || (r_ferr && !w_rd_stat);
      r_ovf  <= w_ovf_set  || (r_ovf  && !w_rd_stat);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state     <= RX_IDLE;
      r_rx_cnt       <= '0;
      r_rx_bit       <= '0;
      r_rx_shift     <= '0;
      r_rx_wait_high <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_rx_bit_done) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // After a framing error, hold off until the line idles high again.
          if (r_rx_wait_high) begin
            if (r_rx_sync) begin
              r_rx_wait_high <= 1'b0;
              r_rx_state     <= RX_IDLE;
            end
          end else if (w_rx_bit_done) begin
            r_rx_cnt <= '0;
            if (r_rx_sync) r_rx_state     <= RX_IDLE;
            else           r_rx_wait_high <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder with CLKS_PER_BIT=4, FIFO_DEPTH=8.

module tb_uart_bus_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic [31:0] data_rd;
  logic [31:0] data_rd_2;
  logic        stall;
  logic        txd;
  logic        rxd_in;
  logic        rxd_drv;
  logic        loop_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic       mon_en = 1'b0;
  logic [7:0] mon_bytes[$];
  longint     mon_times[$];

  assign rxd_in = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_bus_responder #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .read(read), .write(write),
    .data_wr(data_wr), .mask(mask), .data_rd(data_rd), .data_rd_2(data_rd_2),
    .stall(stall), .txd(txd), .rxd(rxd_in)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [7:0] b, output int stall_cycles);
    write   = 1'b1;
    address = 32'h0;
    data_wr = {24'h0, b};
    mask    = 4'h1;
    stall_cycles = 0;
    @(negedge clk);
    while (stall && stall_cycles < 2000) begin
      stall_cycles++;
      @(negedge clk);
    end
    if (stall_cycles >= 2000) check_val("write_stall_timeout", 32'(stall_cycles), 32'h0);
    @(posedge clk);
    #1;
    write = 1'b0;
    $display("write %h stalled %0d cycles", b, stall_cycles);
  endtask

  task automatic do_read(input logic stat, output logic [31:0] d);
    read    = 1'b1;
    address = stat ? 32'h4 : 32'h0;
    @(negedge clk);
    d = data_rd;
    @(posedge clk);
    #1;
    read = 1'b0;
    $display("read %s -> %h", stat ? "STATUS" : "DATA", d);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (4) @(posedge clk);
      #1;
    end
    rxd_drv = stop_bit;
    repeat (4) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    $display("rx frame %h stop=%0d sent", b, stop_bit);
  endtask

  // Independent txd decoder: catches the start bit and samples each bit mid-cell.
  initial begin
    logic [7:0] b;
    longint t0;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        t0 = longint'($time);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = txd;
          if (i < 7) repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_val("mon_stop_bit", {31'h0, txd}, 32'h1);
        mon_bytes.push_back(b);
        mon_times.push_back(t0);
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  a5_bits;
    logic [7:0]  bp_exp[10];
    int          sc;
    int          lows;

    rst_n = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    data_wr = '0; mask = '0; rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset / idle
    @(negedge clk);
    check_val("rst_txd", {31'h0, txd}, 32'h1);
    check_val("rst_stall", {31'h0, stall}, 32'h0);
    check_val("rst_data_rd_2", data_rd_2, 32'h0);
    @(posedge clk); #1;
    do_read(1'b1, d); check_val("rst_status", d, 32'h1);
    do_read(1'b0, d); check_val("rst_data", d, 32'h0);

    // Single TX frame of 8'hA5: 0,1,0,1,0,0,1,0,1,1 (index 0 first)
    a5_bits = 10'b1101001010;
    do_write(8'hA5, sc);
    check_val("a5_no_stall", 32'(sc), 32'h0);
    @(negedge clk);
    check_val("a5_idle_at_push", {31'h0, txd}, 32'h1);
    @(negedge clk);
    check_val("a5_start_latency", {31'h0, txd}, 32'h0);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 1 : 4) @(negedge clk);
      check_val($sformatf("a5_bit%0d", k), {31'h0, txd}, {31'h0, a5_bits[k]});
    end
    repeat (10) @(posedge clk); #1;

    // Back-pressure: one byte occupies the shifter, eight fill the FIFO, the ninth stalls.
    bp_exp = '{8'h5A, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    mon_bytes.delete(); mon_times.delete();
    mon_en = 1'b1;
    do_write(8'h5A, sc);
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      do_write(8'h10 + 8'(k), sc);
      check_val($sformatf("bp_nostall%0d", k), 32'(sc), 32'h0);
    end
    do_read(1'b1, d); check_val("bp_status_full", d, 32'h0);
    do_write(8'h18, sc);
    check_val("bp_ninth_stalled", {31'h0, sc > 0}, 32'h1);
    repeat (420) @(posedge clk); #1;
    mon_en = 1'b0;
    check_val("bp_frame_count", 32'(mon_bytes.size()), 32'd10);
    for (int k = 0; k < 10 && k < mon_bytes.size(); k++)
      check_val($sformatf("bp_byte%0d", k), {24'h0, mon_bytes[k]}, {24'h0, bp_exp[k]});
    for (int k = 1; k < 10 && k < mon_times.size(); k++)
      check_val($sformatf("bp_gap%0d", k), 32'(mon_times[k] - mon_times[k-1]), 32'd400);

    // Loopback
    loop_en = 1'b1;
    do_write(8'h3C, sc);
    repeat (60) @(posedge clk); #1;
    do_read(1'b1, d); check_val("lb_status", d, 32'h3);
    do_read(1'b0, d); check_val("lb_data", d, 32'h3C);
    do_read(1'b1, d); check_val("lb_status_after", d, 32'h1);
    loop_en = 1'b0;

    // Framing error, then overflow
    send_rx(8'h55, 1'b0);
    do_read(1'b1, d); check_val("ferr_status", d, 32'h5);
    do_read(1'b1, d); check_val("ferr_cleared", d, 32'h1);
    do_read(1'b0, d); check_val("ferr_no_push", d, 32'h0);
    for (int k = 0; k < 9; k++) send_rx(8'h60 + 8'(k), 1'b1);
    do_read(1'b1, d); check_val("ovf_status", d, 32'hB);
    for (int k = 0; k < 8; k++) begin
      do_read(1'b0, d);
      check_val($sformatf("ovf_data%0d", k), d, 32'h60 + 32'(k));
    end
    do_read(1'b1, d); check_val("ovf_drained", d, 32'h1);

    // Async reset during data bit 3 of 8'hF0, with 8'h77 queued behind it
    do_write(8'hF0, sc);
    do_write(8'h77, sc);
    repeat (17) @(negedge clk);
    check_val("rst_mid_bit3", {31'h0, txd}, 32'h0);
    #1 rst_n = 1'b0;
    #1 check_val("rst_mid_txd_async", {31'h0, txd}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check_val("rst_no_residual", 32'(lows), 32'h0);
    @(posedge clk); #1;
    do_read(1'b1, d); check_val("rst_mid_status", d, 32'h1);
    do_read(1'b0, d); check_val("rst_mid_data", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
